running_max_tracker: RTL and testbench

RUNNING_MAX_TRACKER -- requirements
Module: running_max_tracker

---
 rtl/running_max_tracker_pkg.sv | 18 +
 rtl/running_max_tracker_max4_compare.sv | 21 ++
 rtl/running_max_tracker.sv | 131 +++++++++++++
 tb/tb_running_max_tracker.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/running_max_tracker_pkg.sv
// running_max_tracker_pkg
// Shared definitions for the running maximum tracker and its comparator:
//   DATA_W  - width of samples, maxima, indices and counts (4 bits)
//   word_t  - unsigned DATA_W-bit word
//   state_t - frame-tracking FSM states (IDLE, ACCUM, HOLD)
package running_max_tracker_pkg;

    localparam int DATA_W = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for the first sample of a frame
        ST_ACCUM = 2'd1,  // frame open, folding samples into the running max
        ST_HOLD  = 2'd2   // frame closed, result presented downstream
    } state_t;

endpackage

// File: rtl/running_max_tracker_max4_compare.sv
// max4_compare
// Combinational unsigned comparator / max selector.
// Ports:
//   a         in  current maximum
//   b         in  candidate sample
//   max       out larger of a and b; a wins on a tie
//   b_greater out 1 when b is strictly greater than a
module max4_compare
    import running_max_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] max,
    output logic              b_greater
);

    // Strict compare so that a repeated maximum keeps its earlier position.
    assign b_greater = (b > a);
    assign max       = b_greater ? b : a;

endmodule

// File: rtl/running_max_tracker.sv
// running_max_tracker
// Tracks the maximum of each frame of 4-bit unsigned samples, its first
// position, the number of samples and whether the frame was cut at MAX_LEN.
// Parameter:
//   MAX_LEN   maximum samples per frame (1..15)
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous active-high reset
//   in_valid  in  sample present
//   in_data   in  sample value
//   in_last   in  final sample of the frame
//   in_ready  out a sample can be accepted this cycle (state only)
//   out_valid out frame result present (exactly while in HOLD)
//   out_ready in  downstream accepts the result
//   out_max   out frame maximum
//   out_index out 0-based position of the first occurrence of out_max
//   out_count out samples in the frame
//   out_trunc out frame closed by MAX_LEN rather than in_last
module running_max_tracker
    import running_max_tracker_pkg::*;
#(
    parameter int MAX_LEN = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_index,
    output logic [DATA_W-1:0] out_count,
    output logic              out_trunc
);

    localparam logic [DATA_W-1:0] LEN_LIMIT = DATA_W'(MAX_LEN);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] max_reg, max_next;
    logic [DATA_W-1:0] index_reg, index_next;
    logic [DATA_W-1:0] count_reg, count_next;
    logic              trunc_reg, trunc_next;

    logic [DATA_W-1:0] cmp_max;
    logic              cmp_greater;
    logic [DATA_W-1:0] count_inc;

    max4_compare u_cmp (
        .a         (max_reg),
        .b         (in_data),
        .max       (cmp_max),
        .b_greater (cmp_greater)
    );

    // count_reg is below LEN_LIMIT whenever ACCUM is active, so this never wraps.
    assign count_inc = count_reg + DATA_W'(1);

    always_comb begin
        state_next = state_reg;
        max_next   = max_reg;
        index_next = index_reg;
        count_next = count_reg;
        trunc_next = trunc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    max_next   = in_data;
                    index_next = '0;
                    count_next = DATA_W'(1);
                    trunc_next = 1'b0;
                    if (in_last || (LEN_LIMIT == DATA_W'(1))) begin
                        state_next = ST_HOLD;
                        trunc_next = ~in_last;
                    end else begin
                        state_next = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    count_next = count_inc;
                    if (cmp_greater) begin
                        max_next   = cmp_max;
                        index_next = count_reg;
                    end
                    // in_last wins the trunc flag when both close conditions coincide.
                    if (in_last || (count_inc == LEN_LIMIT)) begin
                        state_next = ST_HOLD;
                        trunc_next = ~in_last;
                    end
                end
            end
            ST_HOLD: begin
                // Result registers are left untouched so they stay stable while held.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            max_reg   <= '0;
            index_reg <= '0;
            count_reg <= '0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            max_reg   <= max_next;
            index_reg <= index_next;
            count_reg <= count_next;
            trunc_reg <= trunc_next;
        end
    end

    assign in_ready  = (state_reg != ST_HOLD);
    assign out_valid = (state_reg == ST_HOLD);
    assign out_max   = max_reg;
    assign out_index = index_reg;
    assign out_count = count_reg;
    assign out_trunc = trunc_reg;

endmodule

// File: tb/tb_running_max_tracker.sv
// tb_running_max_tracker
// Three tracker instances (MAX_LEN = 4, 15, 1) each receive directed frames
// followed by 1000 random frames with random gaps and random back-pressure.
// A frame-level reference model turns accepted samples into expected results
// that a per-instance monitor compares whenever a result is presented.
module tb_running_max_tracker;

    typedef struct {
        logic [3:0] mx;
        logic [3:0] idx;
        logic [3:0] cnt;
        logic       trunc;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function void check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LEN = (gi == 0) ? 4 : ((gi == 1) ? 15 : 1);

        logic       reset, in_valid, in_last, in_ready;
        logic       out_valid, out_ready, out_trunc;
        logic [3:0] in_data, out_max, out_index, out_count;

        res_t       exp_q[$];
        logic [3:0] frame_q[$];
        int         hold_cycles  = 0;
        bit         random_ready = 0;
        bit         last_hs      = 0;
        bit         fin          = 0;

        running_max_tracker #(.MAX_LEN(LEN)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_last   (in_last),
            .in_ready  (in_ready),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_max   (out_max),
            .out_index (out_index),
            .out_count (out_count),
            .out_trunc (out_trunc)
        );

        // Downstream ready: forced low for hold_cycles result cycles, else 1 or random.
        initial begin
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                if (hold_cycles > 0) begin
                    out_ready = 1'b0;
                    if (out_valid) hold_cycles--;
                end else if (random_ready) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    out_ready = 1'b1;
                end
            end
        end

        // Monitor: every presented result must equal the queue head and stay so until taken.
        always @(negedge clk) begin
            if (!reset) begin
                if (last_hs) begin
                    check($sformatf("u%0d idle after accept valid", gi), int'(out_valid), 0);
                    check($sformatf("u%0d idle after accept ready", gi), int'(in_ready), 1);
                end
                last_hs = 0;
                if (out_valid) begin
                    check($sformatf("u%0d in_ready in hold", gi), int'(in_ready), 0);
                    if (exp_q.size() == 0) begin
                        check($sformatf("u%0d unexpected result", gi), 1, 0);
                    end else begin
                        check($sformatf("u%0d max", gi),   int'(out_max),   int'(exp_q[0].mx));
                        check($sformatf("u%0d index", gi), int'(out_index), int'(exp_q[0].idx));
                        check($sformatf("u%0d count", gi), int'(out_count), int'(exp_q[0].cnt));
                        check($sformatf("u%0d trunc", gi), int'(out_trunc), int'(exp_q[0].trunc));
                        if (out_ready) begin
                            $display("u%0d result max=%0d idx=%0d cnt=%0d trunc=%0d",
                                     gi, out_max, out_index, out_count, out_trunc);
                            void'(exp_q.pop_front());
                            last_hs = 1;
                        end
                    end
                end
            end else begin
                last_hs = 0;
            end
        end

        // Reference model: a frame is the list of accepted samples.
        function automatic res_t frame_result(input bit closed_by_last);
            res_t r;
            int   m = 0;
            int   first = -1;
            foreach (frame_q[i]) if (int'(frame_q[i]) > m) m = int'(frame_q[i]);
            foreach (frame_q[i]) if (first < 0 && int'(frame_q[i]) == m) first = i;
            r.mx    = 4'(m);
            r.idx   = 4'(first);
            r.cnt   = 4'(frame_q.size());
            r.trunc = !closed_by_last;
            return r;
        endfunction

        // Called at a negedge; returns at a negedge after the sample was taken.
        task automatic send(input logic [3:0] d, input logic l);
            int waited = 0;
            bit closed = 0;
            in_valid = 1'b1;
            in_data  = d;
            in_last  = l;
            while (!in_ready && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                check($sformatf("u%0d ready timeout", gi), 0, 1);
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                frame_q.push_back(d);
                if (l || frame_q.size() == LEN) begin
                    exp_q.push_back(frame_result(l));
                    frame_q.delete();
                    closed = 1;
                end
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
                check($sformatf("u%0d valid after beat", gi), int'(out_valid), int'(closed));
            end
        endtask

        task automatic idle(input int n);
            repeat (n) @(negedge clk);
        endtask

        task automatic do_reset();
            reset    = 1'b1;
            in_valid = 1'b0;
            @(posedge clk);
            frame_q.delete();
            exp_q.delete();
            @(negedge clk);
            check($sformatf("u%0d rst out_valid", gi), int'(out_valid), 0);
            check($sformatf("u%0d rst out_max", gi),   int'(out_max),   0);
            check($sformatf("u%0d rst out_index", gi), int'(out_index), 0);
            check($sformatf("u%0d rst out_count", gi), int'(out_count), 0);
            check($sformatf("u%0d rst out_trunc", gi), int'(out_trunc), 0);
            check($sformatf("u%0d rst in_ready", gi),  int'(in_ready),  1);
            reset = 1'b0;
        endtask

        initial begin
            int len;
            int waited;
            reset    = 1'b1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
            @(negedge clk);
            do_reset();

            // 3,9,2,9(last): max 9 first at 1
            send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd2, 1'b0); send(4'd9, 1'b1);
            idle(2);
            // 1..5(last): truncation at MAX_LEN
            send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b0);
            send(4'd5, 1'b1);
            idle(2);
            // single zero sample
            send(4'd0, 1'b1);
            idle(1);
            // result held for five cycles while upstream keeps offering
            hold_cycles = 5;
            send(4'd6, 1'b0); send(4'd11, 1'b1); send(4'd8, 1'b1);
            idle(8);
            // reset mid-frame discards the partial frame
            send(4'd7, 1'b0); send(4'd15, 1'b0);
            do_reset();
            send(4'd4, 1'b1);
            idle(3);

            random_ready = 1;
            for (int f = 0; f < 1000; f++) begin
                len = $urandom_range(1, 10);
                for (int k = 0; k < len; k++) begin
                    idle($urandom_range(0, 2));
                    send(4'($urandom_range(0, 15)), (k == len - 1));
                end
            end
            random_ready = 0;

            waited = 0;
            while (exp_q.size() > 0 && waited < 200) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("u%0d results drained", gi), exp_q.size(), 0);
            fin = 1;
        end
    end

    initial begin
        wait (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #600000;
        check("watchdog", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
